delay_meas_core: RTL and testbench

- Measurement stage downstream of the inverter/launch stage.
- Drives a launch edge onto an external loop, waits for the echo on a pad input and counts clk cycles between them.
- Latches the count, with a timeout flag, for readout on the TinyTapeout outputs.
- Instantiated inside tt_um_* top; ui_in supplies control, uo_out/uio_out carry results.

---
 rtl/delay_meas_pkg.sv | 15 +
 rtl/delay_meas_sync.sv | 20 ++
 rtl/delay_meas_core.sv | 133 +++++++++++++
 tb/tb_delay_meas_core.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/delay_meas_pkg.sv
// Shared types and defaults for the loop-delay measurement core.
package delay_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          CNT_W_DEF     = 16;
    localparam logic [15:0] MAX_COUNT_DEF = 16'd50000;
    localparam int          AVG_SHIFT     = 3;

endpackage

// File: rtl/delay_meas_sync.sv
// Echo synchronizer: SYNC_STAGES-deep flop chain, async active-low reset.
module delay_meas_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_in,
    output logic echo_s
);

    logic [SYNC_STAGES-1:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], echo_in};
    end

    assign echo_s = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/delay_meas_core.sv
// Launch/echo round-trip cycle counter with timeout.
// Optional DELAY_MEAS_AVG_EN: report the mean of 8 good samples instead of each one.
module delay_meas_core
    import delay_meas_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MAX_COUNT   = CNT_W'(MAX_COUNT_DEF),
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             echo_in,
    output logic             launch_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] result
);

    localparam logic [CNT_W-1:0] LAST = MAX_COUNT - CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arm_cnt;
    logic             echo_s;

    delay_meas_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo_in(echo_in),
        .echo_s (echo_s)
    );

`ifdef DELAY_MEAS_AVG_EN
    logic [CNT_W+2:0]     acc;
    logic [CNT_W+2:0]     acc_nxt;
    logic [AVG_SHIFT-1:0] samp;

    always_comb acc_nxt = acc + {3'b000, cnt};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            arm_cnt    <= '0;
            launch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            result     <= '0;
`ifdef DELAY_MEAS_AVG_EN
            acc        <= '0;
            samp       <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (!ena) begin
                // abort without touching result/timeout
                state      <= IDLE;
                launch_out <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state   <= ARM;
                        busy    <= 1'b1;
                        arm_cnt <= '0;
                    end
                    ARM: begin
                        if (!echo_s) begin
                            state      <= WAIT;
                            launch_out <= 1'b1;
                            cnt        <= '0;
                        end else if (arm_cnt == LAST) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
`ifdef DELAY_MEAS_AVG_EN
                            acc     <= '0;
                            samp    <= '0;
`endif
                        end else begin
                            arm_cnt <= arm_cnt + CNT_W'(1);
                        end
                    end
                    WAIT: begin
                        if (echo_s) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            launch_out <= 1'b0;
`ifdef DELAY_MEAS_AVG_EN
                            if (samp == '1) begin
                                result  <= acc_nxt[AVG_SHIFT +: CNT_W];
                                timeout <= 1'b0;
                                done    <= 1'b1;
                                acc     <= '0;
                                samp    <= '0;
                            end else begin
                                acc     <= acc_nxt;
                                samp    <= samp + 1'b1;
                            end
`else
                            result     <= cnt;
                            timeout    <= 1'b0;
                            done       <= 1'b1;
`endif
                        end else if (cnt == LAST) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            launch_out <= 1'b0;
                            result     <= MAX_COUNT;
                            timeout    <= 1'b1;
                            done       <= 1'b1;
`ifdef DELAY_MEAS_AVG_EN
                            acc        <= '0;
                            samp       <= '0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delay_meas_core.sv
// Scoreboard bench for delay_meas_core with a programmable loop-delay echo model.
module tb_delay_meas_core;

    typedef struct packed {
        logic [15:0] res;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic        echo_in;
    logic        launch_out, busy, done, timeout;
    logic [15:0] result;

    logic [31:0] dl;
    int          dly = 10;
    int          echo_mode = 0;   // 0: loop model, 1: forced low, 2: forced high
    int          n_chk = 0, n_err = 0, n_done = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int          hi;

    delay_meas_core #(.CNT_W(16), .MAX_COUNT(16'd100), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .echo_in   (echo_in),
        .launch_out(launch_out),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .result    (result)
    );

    always #5 clk = ~clk;

    // external loop: echo_in follows launch_out dly clock cycles later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dl <= '0;
        else        dl <= {dl[30:0], launch_out};
    end
    assign echo_in = (echo_mode == 1) ? 1'b0 : (echo_mode == 2) ? 1'b1 : dl[dly-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", 32'(result), 32'(mon_e.res));
                chk("timeout", 32'(timeout), 32'(mon_e.to));
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int hi_cnt);
        int n = 0;
        logic seen = 1'b0;
        hi_cnt = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (launch_out) hi_cnt++;
            if (done) seen = 1'b1;
            n++;
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_flag(input string tag, input logic want_launch, input int budget);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            seen = want_launch ? launch_out : !busy;
            n++;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #23;
        chk("rst_launch", 32'(launch_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

`ifdef DELAY_MEAS_AVG_EN
        // 12,12,12,12,14,14,14,14 -> 104/8
        sb.push_back('{res: 16'd13, to: 1'b0});
        for (int i = 0; i < 8; i++) begin
            dly = (i < 4) ? 10 : 12;
            pulse_start();
            wait_flag("avg_idle", 1'b0, 300);
            repeat (40) @(negedge clk);
        end
        chk("avg_result", 32'(result), 32'd13);
        chk("done_total", 32'(n_done), 32'd1);
`else
        // delay 10 + 2 sync stages
        dly = 10;
        sb.push_back('{res: 16'd12, to: 1'b0});
        pulse_start();
        chk("busy_run", 32'(busy), 32'd1);
        wait_done(300, hi);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("launch_span", 32'(hi), 32'd13);
        repeat (40) @(negedge clk);

        // no echo: 100 WAIT cycles then timeout
        echo_mode = 1;
        sb.push_back('{res: 16'd100, to: 1'b1});
        pulse_start();
        wait_done(300, hi);
        chk("to_span", 32'(hi), 32'd100);
        echo_mode = 0;
        repeat (40) @(negedge clk);

        sb.push_back('{res: 16'd12, to: 1'b0});
        pulse_start();
        wait_done(300, hi);
        repeat (40) @(negedge clk);

        // echo stuck high: ARM timeout, result kept
        echo_mode = 2;
        repeat (5) @(negedge clk);
        sb.push_back('{res: 16'd12, to: 1'b1});
        pulse_start();
        wait_done(300, hi);
        chk("arm_no_launch", 32'(hi), 32'd0);
        echo_mode = 0;
        repeat (40) @(negedge clk);

        // start re-pulsed mid-WAIT is ignored
        dly = 20;
        sb.push_back('{res: 16'd22, to: 1'b0});
        pulse_start();
        wait_flag("launch_seen", 1'b1, 50);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_done(300, hi);
        repeat (40) @(negedge clk);
        chk("no_requeue", 32'(busy), 32'd0);

        // ena drop aborts without done
        pulse_start();
        wait_flag("launch_seen", 1'b1, 50);
        repeat (5) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("abort_launch", 32'(launch_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_result", 32'(result), 32'd22);
        chk("abort_timeout", 32'(timeout), 32'd0);

        // async reset mid-WAIT
        pulse_start();
        wait_flag("launch_seen", 1'b1, 50);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_launch", 32'(launch_out), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_timeout", 32'(timeout), 32'd0);
        chk("mrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("done_total", 32'(n_done), 32'd5);
`endif
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
